// File: rtl/pha_pkg.sv
// ----------------------------------------------------------------------------
// pha_pkg
// Shared types and constants for the pulse-height analyser.
//   - pha_state_e   : acquisition state (IDLE / PULSE)
//   - pha_event_t   : event record at the default sample/timestamp widths
//   - WIDTH_W       : width of the pulse-width field
//   - DROP_W        : width of the dropped-event counter
//   - width_sat_inc : saturating increment of the pulse-width counter
// ----------------------------------------------------------------------------
package pha_pkg;

    localparam int WIDTH_W    = 8;
    localparam int DROP_W     = 16;
    localparam int DATA_W_DEF = 14;
    localparam int TS_W_DEF   = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } pha_state_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] height;
        logic [WIDTH_W-1:0]    width;
        logic [TS_W_DEF-1:0]   time_stamp;
        logic                  long_flag;
    } pha_event_t;

    // Width grows by one per sample and sticks at the saturation point.
    function automatic logic [WIDTH_W-1:0] width_sat_inc(
        input logic [WIDTH_W-1:0] w,
        input logic [WIDTH_W-1:0] max_w
    );
        if (w < max_w) begin
            return w + WIDTH_W'(1);
        end else begin
            return max_w;
        end
    endfunction

endpackage

// File: rtl/pha_evt_if.sv
// ----------------------------------------------------------------------------
// pha_evt_if
// Valid/ready event stream from the analyser to its consumer.
//   evt_valid  : head event present (master -> slave)
//   evt_ready  : consumer accepts head (slave -> master)
//   evt_height : peak sample
//   evt_width  : samples above threshold, saturating
//   evt_time   : timestamp of the first occurrence of the peak
//   evt_long   : width reached saturation
// ----------------------------------------------------------------------------
interface pha_evt_if #(
    parameter int DATA_W = 14,
    parameter int TS_W   = 32
);
    import pha_pkg::*;

    logic                evt_valid;
    logic                evt_ready;
    logic [DATA_W-1:0]   evt_height;
    logic [WIDTH_W-1:0]  evt_width;
    logic [TS_W-1:0]     evt_time;
    logic                evt_long;

    modport master (
        output evt_valid,
        input  evt_ready,
        output evt_height,
        output evt_width,
        output evt_time,
        output evt_long
    );

    modport slave (
        input  evt_valid,
        output evt_ready,
        input  evt_height,
        input  evt_width,
        input  evt_time,
        input  evt_long
    );

endinterface

// File: rtl/pha_event_fifo.sv
// ----------------------------------------------------------------------------
// pha_event_fifo
// Show-ahead FIFO built as a shift register: entry 0 is always the head, so
// the read data and valid flag come straight from flops with no read latency.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write request, wdata_i payload
//   pop_i      : consumer accepts head (ignored while empty)
//   rdata_o    : head payload, valid_o head valid
//   full_o     : no free entry, empty_o no entry
// ----------------------------------------------------------------------------
module pha_event_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         valid_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int                CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q   [DEPTH];
    logic [W-1:0]     mem_d   [DEPTH];
    logic [W-1:0]     shift_s [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx_s;
    logic             valid_q;
    logic             pop_s;
    logic             push_s;

    assign pop_s   = pop_i && valid_q;
    assign full_o  = (count_q == DEPTH_C);
    assign push_s  = push_i && (!full_o || pop_s);
    assign rdata_o = mem_q[0];
    assign valid_o = valid_q;
    assign empty_o = !valid_q;

    // Next storage contents: shift down on pop, then drop the new entry into
    // the first free slot (one lower when a pop frees the head).
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            shift_s[i] = pop_s ? mem_q[i+1] : mem_q[i];
        end
        shift_s[DEPTH-1] = mem_q[DEPTH-1];

        if (pop_s) begin
            wr_idx_s = count_q - CNT_W'(1);
        end else begin
            wr_idx_s = count_q;
        end

        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (push_s && (CNT_W'(i) == wr_idx_s)) ? wdata_i : shift_s[i];
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, occupancy and registered head-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

endmodule

// File: rtl/pulse_height_analyzer.sv
// ----------------------------------------------------------------------------
// pulse_height_analyzer
// Single-channel pulse-height analyser. A pulse starts when an armed sample
// exceeds THRESH_HI and ends at the first sample at or below THRESH_LO. The
// peak, its first timestamp and the pulse width are captured; pulses at least
// MIN_WIDTH wide are pushed into an event FIFO, and events that find the FIFO
// full are counted in drop_count.
//   clk, rst_n : sample clock, asynchronous active-low reset
//   ad_data    : ADC sample, one per clock
//   en         : arm; only gates the start of a pulse
//   evt        : valid/ready event stream (master side)
//   drop_count : events lost to a full FIFO, saturating
//   busy       : a pulse is in progress
// ----------------------------------------------------------------------------
module pulse_height_analyzer
    import pha_pkg::*;
#(
    parameter int                DATA_W     = 14,
    parameter logic [DATA_W-1:0] THRESH_HI  = 14'h1900,
    parameter logic [DATA_W-1:0] THRESH_LO  = 14'h1880,
    parameter int                MIN_WIDTH  = 2,
    parameter int                MAX_WIDTH  = 255,
    parameter int                TS_W       = 32,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              en,
    pha_evt_if.master         evt,
    output logic [DROP_W-1:0] drop_count,
    output logic              busy
);

    localparam int                 PAY_W   = DATA_W + WIDTH_W + TS_W + 1;
    localparam logic [WIDTH_W-1:0] MIN_W_C = WIDTH_W'(MIN_WIDTH);
    localparam logic [WIDTH_W-1:0] MAX_W_C = WIDTH_W'(MAX_WIDTH);

    pha_state_e        state_q;
    logic [DATA_W-1:0] peak_q;
    logic [TS_W-1:0]   peak_ts_q;
    logic [WIDTH_W-1:0] width_q;
    logic              busy_q;
    logic [TS_W-1:0]   ts_q;
    logic [DROP_W-1:0] drop_q;

    logic              pulse_end_s;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_valid_s;
    logic [PAY_W-1:0]  push_data_s;
    logic [PAY_W-1:0]  head_s;

    // The ending sample is not part of the pulse, so width_q is final here.
    assign pulse_end_s = (state_q == PULSE) && (ad_data <= THRESH_LO);
    assign push_s      = pulse_end_s && (width_q >= MIN_W_C);
    assign pop_s       = !fifo_empty_s && evt.evt_ready;
    assign drop_s      = push_s && fifo_full_s && !pop_s;
    assign push_data_s = {peak_q, width_q, peak_ts_q, (width_q == MAX_W_C)};

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Acquisition FSM with peak tracker and width counter; busy is registered
    // alongside the state so it mirrors PULSE exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            peak_q    <= '0;
            peak_ts_q <= '0;
            width_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && (ad_data > THRESH_HI)) begin
                        state_q   <= PULSE;
                        busy_q    <= 1'b1;
                        peak_q    <= ad_data;
                        peak_ts_q <= ts_q;
                        width_q   <= WIDTH_W'(1);
                    end else begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                PULSE: begin
                    if (ad_data <= THRESH_LO) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        width_q <= width_sat_inc(width_q, MAX_W_C);
                        // Strict compare keeps the time of the first maximum.
                        if (ad_data > peak_q) begin
                            peak_q    <= ad_data;
                            peak_ts_q <= ts_q;
                        end else begin
                            peak_q    <= peak_q;
                            peak_ts_q <= peak_ts_q;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of events that found the FIFO full without a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (drop_s && (drop_q != {DROP_W{1'b1}})) begin
            drop_q <= drop_q + DROP_W'(1);
        end else begin
            drop_q <= drop_q;
        end
    end

    pha_event_fifo #(
        .W     (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .wdata_i (push_data_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .valid_o (fifo_valid_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign evt.evt_valid  = fifo_valid_s;
    assign evt.evt_height = head_s[PAY_W-1 -: DATA_W];
    assign evt.evt_width  = head_s[TS_W+WIDTH_W : TS_W+1];
    assign evt.evt_time   = head_s[TS_W:1];
    assign evt.evt_long   = head_s[0];
    assign drop_count     = drop_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_pulse_height_analyzer.sv
// ----------------------------------------------------------------------------
// tb_pulse_height_analyzer
// Directed bench: inputs change just after the falling edge, outputs are
// checked at the next falling edge, i.e. after the rising edge that consumed
// the sample. ts_ref counts rising edges since reset release, which is the
// timestamp value the design attaches to a sample driven at that moment.
// ----------------------------------------------------------------------------
module tb_pulse_height_analyzer;

    logic        clk;
    logic        rst_n;
    logic [13:0] ad_data;
    logic        en;
    logic [15:0] drop_count;
    logic        busy;
    logic [31:0] ts_ref;

    int n_assert;
    int n_fail;

    logic [31:0] t_a;
    logic [31:0] t_7;
    logic [13:0] h;
    logic [31:0] bp_t   [6];
    logic [13:0] exp_h  [4];
    logic [31:0] exp_t  [4];

    pha_evt_if #(.DATA_W(14), .TS_W(32)) evt_if ();

    pulse_height_analyzer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ad_data    (ad_data),
        .en         (en),
        .evt        (evt_if),
        .drop_count (drop_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_ref <= 32'd0;
        else        ts_ref <= ts_ref + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [13:0] s);
        ad_data = s;
        @(negedge clk);
    endtask

    task automatic chk_evt(input string tag, input logic [13:0] eh, input logic [7:0] ew,
                           input logic [31:0] et, input logic el);
        chk({tag, "_valid"},  32'(evt_if.evt_valid),  32'd1);
        chk({tag, "_height"}, 32'(evt_if.evt_height), 32'(eh));
        chk({tag, "_width"},  32'(evt_if.evt_width),  32'(ew));
        chk({tag, "_time"},   evt_if.evt_time,        et);
        chk({tag, "_long"},   32'(evt_if.evt_long),   32'(el));
    endtask

    task automatic pop_one(input string tag);
        evt_if.evt_ready = 1'b1;
        drive(14'h1000);
        evt_if.evt_ready = 1'b0;
        chk({tag, "_empty_after_pop"}, 32'(evt_if.evt_valid), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},  32'(evt_if.evt_valid),  32'd0);
        chk({tag, "_height"}, 32'(evt_if.evt_height), 32'd0);
        chk({tag, "_width"},  32'(evt_if.evt_width),  32'd0);
        chk({tag, "_time"},   evt_if.evt_time,        32'd0);
        chk({tag, "_long"},   32'(evt_if.evt_long),   32'd0);
        chk({tag, "_drop"},   32'(drop_count),        32'd0);
        chk({tag, "_busy"},   32'(busy),              32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        ad_data  = 14'h0000;
        evt_if.evt_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        en    = 1'b1;

        // Single pulse: 1000, 1A00, 1C00, 1B00, 1000
        drive(14'h1000);
        chk("single_busy_idle", 32'(busy), 32'd0);
        drive(14'h1A00);
        chk("single_busy_start", 32'(busy), 32'd1);
        t_a = ts_ref;
        drive(14'h1C00);
        drive(14'h1B00);
        chk("single_no_evt_yet", 32'(evt_if.evt_valid), 32'd0);
        drive(14'h1000);
        chk("single_busy_end", 32'(busy), 32'd0);
        chk_evt("single", 14'h1C00, 8'd3, t_a, 1'b0);
        pop_one("single");

        // Hysteresis: 1890 is above THRESH_LO so the pulse continues
        t_a = ts_ref;
        drive(14'h1901);
        drive(14'h1890);
        drive(14'h1890);
        drive(14'h1890);
        chk("hyst_busy", 32'(busy), 32'd1);
        drive(14'h1800);
        chk_evt("hyst", 14'h1901, 8'd4, t_a, 1'b0);
        pop_one("hyst");

        // Short pulse (width 1) is discarded silently
        drive(14'h1901);
        drive(14'h1800);
        chk("short_no_evt", 32'(evt_if.evt_valid), 32'd0);
        drive(14'h1000);
        chk("short_no_evt_late", 32'(evt_if.evt_valid), 32'd0);
        chk("short_no_drop", 32'(drop_count), 32'd0);

        // Repeated peak keeps the first timestamp
        drive(14'h1A00);
        t_a = ts_ref;
        drive(14'h1B00);
        drive(14'h1B00);
        drive(14'h1000);
        chk_evt("rep_peak", 14'h1B00, 8'd3, t_a, 1'b0);
        pop_one("rep_peak");

        // Long pulse: 300 samples saturate width at 255
        t_a = ts_ref;
        for (int i = 0; i < 300; i++) drive(14'h1F00);
        chk("long_busy", 32'(busy), 32'd1);
        chk("long_no_evt_yet", 32'(evt_if.evt_valid), 32'd0);
        drive(14'h1000);
        chk_evt("long", 14'h1F00, 8'd255, t_a, 1'b1);
        pop_one("long");

        // Backpressure: six pulses into a four-entry FIFO
        for (int k = 0; k < 6; k++) begin
            h = 14'h1A10 + 14'(k * 16);
            bp_t[k] = ts_ref;
            drive(h);
            drive(h);
            drive(14'h1000);
            drive(14'h1000);
            chk("bp_head_stable_h", 32'(evt_if.evt_height), 32'h1A10);
            chk("bp_head_stable_t", evt_if.evt_time, bp_t[0]);
        end
        chk("bp_drop2", 32'(drop_count), 32'd2);
        chk_evt("bp_head", 14'h1A10, 8'd2, bp_t[0], 1'b0);

        // Push coincident with pop while full: no drop
        t_7 = ts_ref;
        drive(14'h1A70);
        drive(14'h1A70);
        evt_if.evt_ready = 1'b1;
        drive(14'h1000);
        evt_if.evt_ready = 1'b0;
        chk("bp_coincident_drop", 32'(drop_count), 32'd2);

        exp_h[0] = 14'h1A20; exp_t[0] = bp_t[1];
        exp_h[1] = 14'h1A30; exp_t[1] = bp_t[2];
        exp_h[2] = 14'h1A40; exp_t[2] = bp_t[3];
        exp_h[3] = 14'h1A70; exp_t[3] = t_7;
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_evt("bp_pop", exp_h[i], 8'd2, exp_t[i], 1'b0);
            drive(14'h1000);
        end
        evt_if.evt_ready = 1'b0;
        chk("bp_drained", 32'(evt_if.evt_valid), 32'd0);

        // en low at the rising edge blocks a start
        en = 1'b0;
        drive(14'h1A00);
        chk("en_low_busy", 32'(busy), 32'd0);
        drive(14'h1A00);
        drive(14'h1000);
        chk("en_low_no_evt", 32'(evt_if.evt_valid), 32'd0);

        // en dropped mid-pulse still completes the event
        en = 1'b1;
        t_a = ts_ref;
        drive(14'h1A00);
        en = 1'b0;
        drive(14'h1900);
        drive(14'h1000);
        chk_evt("en_drop", 14'h1A00, 8'd2, t_a, 1'b0);
        pop_one("en_drop");
        en = 1'b1;

        // Fill the FIFO, start a pulse, then reset asynchronously mid-cycle
        for (int k = 0; k < 4; k++) begin
            h = 14'h1B10 + 14'(k * 16);
            drive(h);
            drive(h);
            drive(14'h1000);
        end
        drive(14'h1A00);
        drive(14'h1A00);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        chk("rst_pre_valid", 32'(evt_if.evt_valid), 32'd1);
        chk("rst_pre_drop", 32'(drop_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        ad_data = 14'h1000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(14'h1000);
        drive(14'h1000);
        drive(14'h1000);
        chk_all_zero("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
